// File: rtl/instruction_memory_param.sv
// ============================================================================
// Module      : instruction_memory_param
// Description : Parametrised instruction memory with a 1- or 2-cycle fetch
//               pipeline, fault reporting and a runtime program-load port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_memory_param #(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    DEPTH        = 64,
  parameter int                    READ_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD     = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  input  logic                  fetch_stall,
  output logic [DATA_WIDTH-1:0] instruction,
  output logic                  instr_valid,
  output logic                  fetch_fault,
  input  logic                  load_en,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  load_err
);

  localparam int IDX_W = $clog2(DEPTH);

  generate
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
      $error("instruction_memory_param: READ_LATENCY must be 1 or 2");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("instruction_memory_param: DEPTH must be a power of two >= 2");
    end
  endgenerate

  // Any set bit above the word index makes the address out of range; no wrap.
  function automatic logic addr_bad(input logic [ADDR_WIDTH-1:0] a);
    return (a[1:0] != 2'b00) || ((a >> (IDX_W + 2)) != '0);
  endfunction

  logic [DATA_WIDTH-1:0] r_mem [DEPTH] = '{default: NOP_WORD};

  logic             w_accept;
  logic             w_fetch_bad;
  logic             w_load_bad;
  logic [IDX_W-1:0] w_fetch_idx;
  logic [IDX_W-1:0] w_load_idx;

  assign w_accept    = fetch_req & ~fetch_stall;
  assign w_fetch_bad = addr_bad(fetch_addr);
  assign w_load_bad  = addr_bad(load_addr);
  assign w_fetch_idx = fetch_addr[IDX_W+1:2];
  assign w_load_idx  = load_addr[IDX_W+1:2];

  // Loads ignore the stall; the fetch read below sees the pre-write word.
  always_ff @(posedge clk) begin
    if (load_en && !w_load_bad) begin
      r_mem[w_load_idx] <= load_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_err <= 1'b0;
    end else begin
      load_err <= load_en & w_load_bad;
    end
  end

  logic                  r_s1_valid;
  logic                  r_s1_fault;
  logic [DATA_WIDTH-1:0] r_s1_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_fault <= 1'b0;
      r_s1_data  <= '0;
    end else if (!fetch_stall) begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_fault <= w_fetch_bad;
        r_s1_data  <= w_fetch_bad ? NOP_WORD : r_mem[w_fetch_idx];
      end
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                  r_s2_valid;
      logic                  r_s2_fault;
      logic [DATA_WIDTH-1:0] r_s2_data;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_s2_valid <= 1'b0;
          r_s2_fault <= 1'b0;
          r_s2_data  <= '0;
        end else if (!fetch_stall) begin
          r_s2_valid <= r_s1_valid;
          if (r_s1_valid) begin
            r_s2_fault <= r_s1_fault;
            r_s2_data  <= r_s1_data;
          end
        end
      end

      assign instruction = r_s2_data;
      assign instr_valid = r_s2_valid;
      assign fetch_fault = r_s2_fault;
    end else begin : g_lat1
      assign instruction = r_s1_data;
      assign instr_valid = r_s1_valid;
      assign fetch_fault = r_s1_fault;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_instruction_memory_param.sv
// ============================================================================
// Module      : tb_instruction_memory_param
// Description : Randomised + directed bench for three configurations of
//               instruction_memory_param against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instruction_memory_param;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_addr = '0;
  logic        fetch_stall = 1'b0;
  logic        load_en = 1'b0;
  logic [31:0] load_addr = '0;
  logic [31:0] load_data = '0;

  always #5 clk = ~clk;

  logic [31:0] instr0, instr1;
  logic [15:0] instr2;
  logic        val0, val1, val2, flt0, flt1, flt2, lerr0, lerr1, lerr2;

  // Config 0: defaults. Config 1: two-cycle latency. Config 2: 16x16 words.
  instruction_memory_param u_d0 (
    .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_stall(fetch_stall), .instruction(instr0), .instr_valid(val0),
    .fetch_fault(flt0), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .load_err(lerr0));

  instruction_memory_param #(.READ_LATENCY(2)) u_d1 (
    .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_stall(fetch_stall), .instruction(instr1), .instr_valid(val1),
    .fetch_fault(flt1), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .load_err(lerr1));

  instruction_memory_param #(.DATA_WIDTH(16), .DEPTH(16)) u_d2 (
    .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_stall(fetch_stall), .instruction(instr2), .instr_valid(val2),
    .fetch_fault(flt2), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data[15:0]), .load_err(lerr2));

  logic [31:0] g_instr [3];
  logic        g_valid [3];
  logic        g_fault [3];
  logic        g_lerr  [3];

  always_comb begin
    g_instr[0] = instr0; g_instr[1] = instr1; g_instr[2] = {16'h0, instr2};
    g_valid[0] = val0;   g_valid[1] = val1;   g_valid[2] = val2;
    g_fault[0] = flt0;   g_fault[1] = flt1;   g_fault[2] = flt2;
    g_lerr[0]  = lerr0;  g_lerr[1]  = lerr1;  g_lerr[2]  = lerr2;
  end

  // Reference model: word store plus a delay line counted in non-stalled edges.
  typedef struct {
    bit          v;
    bit          f;
    logic [31:0] d;
  } ent_t;

  int          lat   [3] = '{1, 2, 1};
  int          lg    [3] = '{6, 6, 4};
  logic [31:0] dmask [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_FFFF};
  logic [31:0] m_mem [3][64];
  ent_t        pipe  [3][$];
  bit          out_v [3];
  bit          out_f [3];
  logic [31:0] out_d [3];
  bit          exp_lerr [3];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_value(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_bad(input int d, input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> (lg[d] + 2)) != 0);
  endfunction

  task automatic model_reset(input int d);
    ent_t e;
    e.v = 0; e.f = 0; e.d = '0;
    pipe[d].delete();
    for (int k = 1; k < lat[d]; k++) pipe[d].push_back(e);
    out_v[d] = 0; out_f[d] = 0; out_d[d] = '0; exp_lerr[d] = 0;
  endtask

  task automatic model_edge(input int d);
    ent_t e;
    bit   fb;
    bit   lb;
    fb = is_bad(d, fetch_addr);
    lb = is_bad(d, load_addr);
    if (!fetch_stall) begin
      e.v = fetch_req;
      e.f = fb;
      e.d = fb ? 32'h0 : m_mem[d][fetch_addr >> 2];
      pipe[d].push_back(e);
      e = pipe[d].pop_front();
      out_v[d] = e.v;
      if (e.v) begin
        out_d[d] = e.d;
        out_f[d] = e.f;
      end
    end
    exp_lerr[d] = load_en && lb;
    if (load_en && !lb) m_mem[d][load_addr >> 2] = load_data & dmask[d];
  endtask

  task automatic compare_all();
    for (int d = 0; d < 3; d++) begin
      check_value($sformatf("d%0d instr_valid", d), 32'(g_valid[d]), 32'(out_v[d]));
      check_value($sformatf("d%0d instruction", d), g_instr[d], out_d[d]);
      if (out_v[d])
        check_value($sformatf("d%0d fetch_fault", d), 32'(g_fault[d]), 32'(out_f[d]));
      check_value($sformatf("d%0d load_err", d), 32'(g_lerr[d]), 32'(exp_lerr[d]));
    end
  endtask

  task automatic step();
    for (int d = 0; d < 3; d++) begin
      if (!rst_n) model_reset(d);
      else        model_edge(d);
    end
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic drive(input bit req, input logic [31:0] fa, input bit stall,
                       input bit le, input logic [31:0] la, input logic [31:0] ld);
    fetch_req = req; fetch_addr = fa; fetch_stall = stall;
    load_en = le; load_addr = la; load_data = ld;
    step();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(0, 32'h0, 0, 0, 32'h0, 32'h0);
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 5))
      0:       return 32'($urandom_range(0, 15)) << 2;
      1:       return 32'($urandom_range(0, 63)) << 2;
      2:       return (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(1, 3));
      3:       return 32'h100 + (32'($urandom_range(0, 63)) << 2);
      4:       return 32'($urandom_range(14, 16)) << 2;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    for (int d = 0; d < 3; d++) begin
      for (int w = 0; w < 64; w++) m_mem[d][w] = '0;
      model_reset(d);
    end
    #1;
    compare_all();
    step();
    step();
    rst_n = 1'b1;
    idle(1);

    // Program load then back-to-back fetches.
    drive(0, 0, 0, 1, 32'h0, 32'hAAA0_0002);
    drive(0, 0, 0, 1, 32'h4, 32'hCB02_0066);
    drive(1, 32'h0, 0, 0, 0, 0);
    drive(1, 32'h4, 0, 0, 0, 0);
    idle(3);

    // Fault cases and a dropped load.
    drive(1, 32'h6, 0, 0, 0, 0);
    drive(1, 32'h100, 0, 0, 0, 0);
    drive(1, 32'hFC, 0, 0, 0, 0);
    drive(1, 32'h3C, 0, 0, 0, 0);
    drive(1, 32'h40, 0, 1, 32'h102, 32'hDEAD_BEEF);
    idle(3);
    drive(1, 32'h0, 0, 0, 0, 0);
    drive(1, 32'h4, 0, 0, 0, 0);
    idle(3);

    // Stream with a two-cycle stall; stalled requests must vanish.
    drive(0, 0, 0, 1, 32'h8, 32'h0BAD_F00D);
    drive(1, 32'h0, 0, 0, 0, 0);
    drive(1, 32'h4, 0, 0, 0, 0);
    drive(1, 32'hC, 1, 0, 0, 0);
    drive(1, 32'hC, 1, 0, 0, 0);
    drive(1, 32'h8, 0, 0, 0, 0);
    idle(4);

    // Same-edge load and fetch to one word: old word first, then new.
    drive(1, 32'h8, 0, 1, 32'h8, 32'h1234_5678);
    drive(1, 32'h8, 0, 0, 0, 0);
    idle(3);

    // Asynchronous reset between edges with a two-cycle fetch in flight.
    drive(1, 32'h4, 0, 0, 0, 0);
    fetch_req = 0;
    #3;
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      check_value($sformatf("d%0d async instr_valid", d), 32'(g_valid[d]), 32'h0);
      check_value($sformatf("d%0d async instruction", d), g_instr[d], 32'h0);
      check_value($sformatf("d%0d async fetch_fault", d), 32'(g_fault[d]), 32'h0);
    end
    step();
    rst_n = 1'b1;
    idle(3);
    drive(1, 32'h0, 0, 0, 0, 0);
    drive(1, 32'h4, 0, 0, 0, 0);
    drive(1, 32'h8, 0, 0, 0, 0);
    idle(3);

    // Randomised traffic.
    for (int k = 0; k < 400; k++) begin
      drive($urandom_range(0, 3) != 0, rand_addr(), $urandom_range(0, 4) == 0,
            $urandom_range(0, 4) == 0, rand_addr(), $urandom);
    end
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
